// File: rtl/ctr_pkg.sv
// Shared constants and state encoding for the CTR keystream consumer and its
// generator: batch geometry, word width and the consumer FSM states.
package ctr_pkg;

  localparam int BATCH_BYTES     = 64;
  localparam int WORD_BYTES      = 4;
  localparam int WORD_W          = WORD_BYTES * 8;
  localparam int BATCH_W         = BATCH_BYTES * 8;
  localparam int WORDS_PER_BATCH = BATCH_BYTES / WORD_BYTES;
  localparam int IDX_W           = $clog2(WORDS_PER_BATCH);
  localparam int LEN_W           = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_KS,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ks_word_buffer.sv
// Holds one keystream batch and serves it one word at a time, MSB word first.
// A load restarts the word index at zero; advance steps to the next word.
module ks_word_buffer
  import ctr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [BATCH_W-1:0] batch,
  input  logic               advance,
  output logic [WORD_W-1:0]  word,
  output logic [IDX_W-1:0]   idx
);

  logic [WORDS_PER_BATCH-1:0][WORD_W-1:0] buf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      idx   <= '0;
    end else if (load) begin
      buf_q <= batch;
      idx   <= '0;
    end else if (advance) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // Word 0 sits in the top 32 bits of the batch.
  assign word = buf_q[IDX_W'(WORDS_PER_BATCH - 1) - idx];

endmodule

// File: rtl/ctr_keystream_xor.sv
// Requests keystream batches, serialises them into words and XORs each word
// with the incoming data stream under valid/ready flow control on both sides.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; total_words sampled here only
// ST_REQ     | one-cycle ks_req pulse to the generator
// ST_WAIT_KS | waiting for the ks_valid pulse carrying the batch
// ST_STREAM  | XOR din words with buffered keystream words
// ST_DRAIN   | last word loaded, waiting for its dout handshake
// ST_DONE    | one-cycle done pulse
module ctr_keystream_xor
  import ctr_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   total_words,
  output logic               busy,
  output logic               done,
  output logic               ks_req,
  input  logic               ks_valid,
  input  logic [BATCH_W-1:0] ks_batch,
  input  logic [WORD_W-1:0]  din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [WORD_W-1:0]  dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last
);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q;
  logic [WORD_W-1:0]  ks_word;
  logic [IDX_W-1:0]   word_idx;
  logic               din_hs, dout_hs, last_word, batch_load;

  assign din_ready  = (state_q == ST_STREAM) && (!dout_valid || dout_ready);
  assign din_hs     = din_valid && din_ready;
  assign dout_hs    = dout_valid && dout_ready;
  assign last_word  = (remaining_q == LEN_W'(1));
  assign batch_load = (state_q == ST_WAIT_KS) && ks_valid;

  ks_word_buffer u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (batch_load),
    .batch   (ks_batch),
    .advance (din_hs),
    .word    (ks_word),
    .idx     (word_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    ks_req  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = (total_words != '0) ? ST_REQ : ST_DONE;
      end
      ST_REQ: begin
        busy    = 1'b1;
        ks_req  = 1'b1;
        state_d = ST_WAIT_KS;
      end
      ST_WAIT_KS: begin
        busy = 1'b1;
        if (ks_valid) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        busy = 1'b1;
        if (din_hs) begin
          if (last_word)                                       state_d = ST_DRAIN;
          else if (word_idx == IDX_W'(WORDS_PER_BATCH - 1))    state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (dout_hs && dout_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      remaining_q <= total_words;
    end else if (din_hs) begin
      remaining_q <= remaining_q - LEN_W'(1);
    end
  end

  // A new word may replace the one being accepted downstream in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (din_hs) begin
      dout       <= din ^ ks_word;
      dout_valid <= 1'b1;
      dout_last  <= last_word;
    end else if (dout_hs) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ctr_keystream_xor.sv
// Directed bench for ctr_keystream_xor: table-driven word vectors per job,
// a small generator model answering ks_req, plus reset and ignore sequences.
module tb_ctr_keystream_xor;
  import ctr_pkg::*;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        last;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  total_words = '0;
  logic         busy, done, ks_req;
  logic         ks_valid = 1'b0;
  logic [511:0] ks_batch = '0;
  logic [31:0]  din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready;
  logic [31:0]  dout;
  logic         dout_valid;
  logic         dout_ready = 1'b1;
  logic         dout_last;

  int           checks = 0;
  int           errors = 0;
  vec_t         tab[$];
  logic [511:0] batches[2];

  ctr_keystream_xor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .total_words (total_words),
    .busy        (busy),
    .done        (done),
    .ks_req      (ks_req),
    .ks_valid    (ks_valid),
    .ks_batch    (ks_batch),
    .din         (din),
    .din_valid   (din_valid),
    .din_ready   (din_ready),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_batch(input logic [31:0] base);
    logic [511:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[511 - 32*k -: 32] = base + 32'(k);
    return b;
  endfunction

  task automatic fill_t1();
    tab.delete();
    tab.push_back('{32'h0000_0000, 32'hA5A5_A5A5, 1'b0});
    tab.push_back('{32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0});
    tab.push_back('{32'h1234_5678, 32'hB791_F3DD, 1'b1});
    batches[0] = {64{8'hA5}};
    batches[1] = '0;
  endtask

  task automatic fill_t2();
    tab.delete();
    for (int k = 0; k < 20; k++)
      tab.push_back('{32'h0, (k < 16) ? 32'h1000 + 32'(k) : 32'h2000 + 32'(k - 16), k == 19});
    batches[0] = mk_batch(32'h1000);
    batches[1] = mk_batch(32'h2000);
  endtask

  // Cycle 1 presents start; outputs are sampled at each falling edge.
  task automatic run_job(input string tag, input int n, input int stall_at,
                         input int stall_len, input int restart_at);
    int cyc = 0, sent = 0, got = 0, kreq = 0, timer = 0;
    int last_hs = -10, done_cyc = -1, hs16 = -1;
    int kreq_cyc[$];
    logic [31:0] prev_dout = '0;
    logic prev_hold = 1'b0;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        done_cyc = cyc;
        chk({tag, " busy_at_done"}, busy, 0);
      end else if (cyc >= 2 && n > 0) begin
        chk({tag, " busy"}, busy, 1);
      end
      ks_valid = 1'b0;
      if (ks_req) begin
        kreq++;
        kreq_cyc.push_back(cyc);
        timer = 2;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) begin
          ks_valid = 1'b1;
          ks_batch = batches[(kreq > 1) ? 1 : 0];
        end
      end
      start       = (cyc == 1) || (cyc == restart_at);
      total_words = (cyc == 1) ? 16'(n) : 16'd5;
      dout_ready  = !(cyc >= stall_at && cyc < stall_at + stall_len);
      din_valid   = (sent < n);
      din         = (sent < n) ? tab[sent].din : 32'h0;
      #1;
      if (prev_hold) begin
        chk({tag, " hold_valid"}, dout_valid, 1);
        chk({tag, " hold_dout"}, dout, prev_dout);
      end
      if (dout_valid && !dout_ready) chk({tag, " stall_din_ready"}, din_ready, 0);
      prev_hold = dout_valid && !dout_ready;
      prev_dout = dout;
      if (din_valid && din_ready) begin
        sent++;
        if (sent == 16) hs16 = cyc;
      end
      if (dout_valid && dout_ready) begin
        if (got < n) begin
          chk($sformatf("%s dout[%0d]", tag, got), dout, tab[got].dout);
          chk($sformatf("%s last[%0d]", tag, got), dout_last, tab[got].last);
        end else begin
          chk({tag, " extra_word"}, got, n);
        end
        got++;
        last_hs = cyc;
      end
    end
    start = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    chk({tag, " done_seen"}, done_cyc > 0, 1);
    chk({tag, " word_count"}, got, n);
    chk({tag, " done_cycle"}, done_cyc, (n == 0) ? 2 : last_hs + 1);
    chk({tag, " ks_req_count"}, kreq, (n + 15) / 16);
    if (n > 16 && kreq_cyc.size() > 1) chk({tag, " refill_req_cycle"}, kreq_cyc[1], hs16 + 1);
    @(negedge clk);
    chk({tag, " done_pulse_end"}, done, 0);
    chk({tag, " idle_busy"}, busy, 0);
  endtask

  initial begin
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ks_req", ks_req, 0);
    chk("reset din_ready", din_ready, 0);
    chk("reset dout_valid", dout_valid, 0);
    chk("reset dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    fill_t1();
    run_job("t1", 3, 0, 0, -1);

    // Stray ks_valid while idle, then start while busy: output must not change.
    @(negedge clk);
    ks_valid = 1'b1;
    ks_batch = {64{8'h3C}};
    @(negedge clk);
    ks_valid = 1'b0;
    run_job("t1_ignore", 3, 0, 0, 6);

    fill_t2();
    run_job("t2", 20, 0, 0, -1);
    run_job("t2_stall", 20, 9, 5, -1);

    run_job("zero", 0, 0, 0, -1);

    // Reset while a word is waiting on a stalled output.
    fill_t1();
    @(negedge clk);
    start = 1'b1;
    total_words = 16'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    ks_valid = 1'b1;
    ks_batch = batches[0];
    @(negedge clk);
    ks_valid = 1'b0;
    din_valid = 1'b1;
    din = 32'h0;
    dout_ready = 1'b0;
    @(negedge clk);
    din_valid = 1'b0;
    #1;
    chk("pre_reset dout_valid", dout_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset busy", busy, 0);
    chk("mid_reset ks_req", ks_req, 0);
    chk("mid_reset din_ready", din_ready, 0);
    chk("mid_reset dout_valid", dout_valid, 0);
    chk("mid_reset dout_last", dout_last, 0);
    chk("mid_reset dout", dout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    run_job("t1_after_reset", 3, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
